rr_select_arbiter: RTL and testbench

- Four-requester round-robin arbiter that produces the 2-bit channel select `sel` for the 2-to-4 decoder stage (`sel` drives the decoder's `A` input directly).
- `grant_valid` qualifies the decoded one-hot output downstream.
- Fair rotation between grants, a bounded hold time per grant, and a mandatory one-cycle idle gap between grants.

---
 rtl/rr_select_arbiter.sv | 65 ++++++
 tb/tb_rr_select_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter: four-way round-robin channel select with bounded hold and a forced idle gap between grants
module rr_select_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       release_in,
    output logic [1:0] sel,
    output logic       grant_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d, ptr_q, ptr_d, win;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d, drop, expire;
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--)
            if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
    assign drop   = release_in || !req[sel_q];
    assign expire = cnt_q == CNT_W'(HOLD_MAX - 1);
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                sel_d   = win;
                cnt_d   = '0;
            end
        end else if (drop || expire) begin
            state_d   = IDLE;
            ptr_d     = sel_q + 2'd1;
            cnt_d     = '0;
            timeout_d = !drop;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign sel         = sel_q;
    assign grant_valid = state_q == GRANT;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb_rr_select_arbiter: three arbiters (HOLD_MAX 15, 3, 1) on shared stimulus, scored against a cycle-level reference model
module tb_rr_select_arbiter;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] req_i = '0;
    logic       rel_i = 1'b0;
    logic [1:0] sel_o [3];
    logic       gv_o  [3];
    logic       to_o  [3];
    int         checks = 0;
    int         failures = 0;
    bit         done = 1'b0;
    int         hm    [3] = '{15, 3, 1};
    bit         busy  [3];
    int         osel  [3];
    int         ptr   [3];
    int         held  [3];
    bit         oto   [3];
    logic [3:0] exp_q [3][$];

    always #5 clk = ~clk;

    rr_select_arbiter #(.HOLD_MAX(15), .CNT_W(8)) u0 (.clk(clk), .rst(rst_i), .req(req_i), .release_in(rel_i),
        .sel(sel_o[0]), .grant_valid(gv_o[0]), .timeout(to_o[0]));
    rr_select_arbiter #(.HOLD_MAX(3), .CNT_W(8)) u1 (.clk(clk), .rst(rst_i), .req(req_i), .release_in(rel_i),
        .sel(sel_o[1]), .grant_valid(gv_o[1]), .timeout(to_o[1]));
    rr_select_arbiter #(.HOLD_MAX(1), .CNT_W(2)) u2 (.clk(clk), .rst(rst_i), .req(req_i), .release_in(rel_i),
        .sel(sel_o[2]), .grant_valid(gv_o[2]), .timeout(to_o[2]));

    // held counts grant cycles already delivered; a grant may deliver at most hm of them
    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            oto[m] = 1'b0;
            if (rst_i) begin
                busy[m] = 1'b0;
                osel[m] = 0;
                ptr[m]  = 0;
            end else if (!busy[m]) begin
                for (int i = 3; i >= 0; i--)
                    if (req_i[(ptr[m] + i) % 4]) osel[m] = (ptr[m] + i) % 4;
                if (req_i != 4'b0) begin
                    busy[m] = 1'b1;
                    held[m] = 1;
                end
            end else if (rel_i || !req_i[osel[m]] || held[m] == hm[m]) begin
                oto[m]  = !(rel_i || !req_i[osel[m]]);
                busy[m] = 1'b0;
                ptr[m]  = (osel[m] + 1) % 4;
            end else begin
                held[m]++;
            end
            exp_q[m].push_back({busy[m], 2'(osel[m]), oto[m]});
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] q, input logic rl, input int n = 1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst_i = r;
            req_i = q;
            rel_i = rl;
            @(posedge clk);
            model_step();
        end
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] got;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                if (exp_q[m].size() > 0) begin
                    e   = exp_q[m].pop_front();
                    got = {gv_o[m], sel_o[m], to_o[m]};
                    checks++;
                    if (got !== e) begin
                        failures++;
                        $display("FAIL out_hm%0d t=%0t gv/sel/to got=%b required=%b", hm[m], $time, got, e);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        cyc(1'b1, 4'b0000, 1'b0, 2);
        cyc(1'b0, 4'b0100, 1'b0, 40);
        cyc(1'b0, 4'b1111, 1'b1, 12);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0, 2);
        cyc(1'b0, 4'b0100, 1'b1);
        cyc(1'b0, 4'b0011, 1'b0, 3);
        cyc(1'b0, 4'b0011, 1'b1);
        cyc(1'b0, 4'b0011, 1'b0, 3);
        cyc(1'b0, 4'b0011, 1'b1);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0010, 1'b0, 5);
        cyc(1'b0, 4'b0000, 1'b0, 2);
        cyc(1'b0, 4'b0001, 1'b0, 3);
        cyc(1'b0, 4'b0001, 1'b1);
        cyc(1'b0, 4'b0001, 1'b0, 8);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1000, 1'b0, 2);
        cyc(1'b1, 4'b1000, 1'b0);
        cyc(1'b0, 4'b1111, 1'b0, 3);
        cyc(1'b0, 4'b1111, 1'b1, 6);
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 7));
            cyc($urandom_range(0, 63) == 0, (r < 2) ? 4'($urandom_range(0, 15)) : req_i,
                $urandom_range(0, 3) == 0);
        end
        cyc(1'b0, 4'b0000, 1'b0, 20);
        repeat (2) @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (exp_q[m].size() != 0) begin
                failures++;
                $display("FAIL drain_hm%0d pending=%0d required=0", hm[m], exp_q[m].size());
            end
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout_guard sim_time=%0t required=finish", $time);
            $fatal(1);
        end
    end
endmodule
